s2p_rx: RTL and testbench
=========================

Name: s2p_rx

Overview:
- Serial-to-parallel receiver for the MSDAP input path.
- Deserialises the framed, MSB-first, bit-serial left/right input streams into parallel words.
- Presents each word pair to the core through a one-deep valid/ack holding register.
- Counterpart of the output-side parallel-to-serial block; shares its SCLK domain and its EN-as-bit-strobe scheme.

Parameters:
DATA_W, 16, bits per received sample word
ZERO_RUN, 800, consecutive all-zero words before zero-detect asserts (only with S2P_ZERO_DETECT_EN)

Ports:
SCLK  input  1  system clock; all logic on posedge
CLR  input  1  asynchronous reset, active high
EN  input  1  bit strobe; serial-side state advances only on SCLK edges with EN=1
FRAME  input  1  frame marker; its rising edge (sampled on EN cycles) marks the MSB
DATAIN_L  input  1  left serial data, MSB first
DATAIN_R  input  1  right serial data, MSB first
PDATA_L  output  DATA_W  received left word
PDATA_R  output  DATA_W  received right word
InReady  output  1  holding register valid
InAck  input  1  consumer accepts word; ignored when InReady=0
FrameErr  output  1  sticky: FRAME rose mid-word
Overrun  output  1  sticky: completed word dropped because holding register full
ZeroDet_L  output  1  left zero-run detected
ZeroDet_R  output  1  right zero-run detected

Behaviour:
- Reset: CLR is asynchronous and active high. All outputs are 0 on reset: PDATA_L, PDATA_R, InReady, FrameErr, Overrun, ZeroDet_L, ZeroDet_R. Shift registers, bit count, frame_d and zero counters clear; state is IDLE. CLR mid-word discards the partial word.
- Edge detect: frame_d <= FRAME on EN cycles only. A rise is FRAME=1 with frame_d=0 on an EN cycle.
- States:
  - IDLE: on a rise, capture DATAIN_L and DATAIN_R as bit DATA_W-1, set cnt=1, go to SHIFT.
  - SHIFT: on each EN cycle, shift in {sr[DATA_W-2:0], DATAIN} and increment cnt.
    - Word completes on the EN edge capturing the DATA_W-th bit (cnt==DATA_W-1 before the edge). On completion, go to IDLE and assert the completion strobe.
    - A rise during SHIFT resynchronises: set FrameErr=1, treat the current bit as the new MSB with cnt=1, stay in SHIFT, discard the partial word.
  - EN=0 freezes all serial-side state.
- Completion vs holding register (same edge as the last bit; InReady visible on the next SCLK cycle):
  - InReady=0: load PDATA_L/PDATA_R, set InReady=1.
  - InReady=1 with InAck=1 on the same edge: load the new word, InReady stays 1.
  - InReady=1 with InAck=0: drop the new word, keep the old one, set Overrun=1.
- Handshake:
  - InAck=1 while InReady=1 and no completion clears InReady on that edge.
  - The handshake is evaluated every SCLK cycle, independent of EN.
  - PDATA holds its value while InReady=0.
- FrameErr and Overrun clear only on CLR.
- Latency: from the EN edge sampling the last bit to InReady high is 1 SCLK edge. A consecutive frame of DATA_W EN cycles sustains full rate.

Optional Feature:
- S2P_ZERO_DETECT_EN defined:
  - Each channel has a saturating counter of consecutive completed words equal to 0; counter width is clog2(ZERO_RUN+1).
  - ZeroDet_x=1 while count>=ZERO_RUN.
  - Any nonzero completed word clears that counter and ZeroDet_x on the same edge.
  - Dropped (overrun) words still update the counters.
- Undefined: the ZeroDet ports remain, tied to 0; no counters are synthesised.

Decomposition:
- Package s2p_pkg: DATA_W default, ZERO_RUN default, state enum {IDLE, SHIFT}, and a count-width constant.
- One sub-module, s2p_chan, holds the per-channel shift register and optional zero counter. It is instantiated for L and R; the FSM, edge detect and handshake stay in the top.

Test Plan:
- Single frame, EN=1 every cycle, L=0xA5C3, R=0x1234 MSB first, InAck=0 -> InReady rises one edge after the 16th bit; PDATA_L=0xA5C3, PDATA_R=0x1234; flags 0.
- EN pulsing 1-in-35, frame L=0x8001 -> same result; no state change on EN=0 cycles; InAck pulse clears InReady next edge.
- Second frame completes while InReady=1 and InAck=0 -> PDATA keeps the first word, Overrun=1; repeat with InAck=1 on the completion edge -> new word loaded, Overrun unchanged.
- FRAME re-rises after 7 bits, then 16 bits of 0x00FF -> FrameErr=1, PDATA_L=0x00FF.
- CLR asserted mid-word (bit 9) then released, full frame 0x7FFF -> all outputs 0 during CLR; next word 0x7FFF received correctly.
- With S2P_ZERO_DETECT_EN: 800 zero words on L -> ZeroDet_L=1 after the 800th, ZeroDet_R=0 with R nonzero; word 0x0001 -> ZeroDet_L=0 the same edge InReady rises.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared constants and types for the MSDAP serial-to-parallel receiver.
// S2P_ZERO_DETECT_EN (see s2p_chan) enables the per-channel zero-run detectors.
package s2p_pkg;
  localparam int DATA_W   = 16;
  localparam int ZERO_RUN = 800;
  localparam int CNT_W    = $clog2(DATA_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/s2p_if.sv
// Serial input / parallel output bundle of the receiver; slave = receiver, master = environment.
interface s2p_if;
  import s2p_pkg::*;

  logic              EN;
  logic              FRAME;
  logic              DATAIN_L;
  logic              DATAIN_R;
  logic [DATA_W-1:0] PDATA_L;
  logic [DATA_W-1:0] PDATA_R;
  logic              InReady;
  logic              InAck;
  logic              FrameErr;
  logic              Overrun;
  logic              ZeroDet_L;
  logic              ZeroDet_R;

  modport slave (
    input  EN, FRAME, DATAIN_L, DATAIN_R, InAck,
    output PDATA_L, PDATA_R, InReady, FrameErr, Overrun, ZeroDet_L, ZeroDet_R
  );

  modport master (
    output EN, FRAME, DATAIN_L, DATAIN_R, InAck,
    input  PDATA_L, PDATA_R, InReady, FrameErr, Overrun, ZeroDet_L, ZeroDet_R
  );
endinterface

// File: rtl/s2p_chan.sv
// One serial channel: MSB-first shift register plus, with S2P_ZERO_DETECT_EN, a
// saturating count of consecutive all-zero completed words.
module s2p_chan
  import s2p_pkg::*;
#(
  parameter int W    = DATA_W,
  parameter int ZRUN = ZERO_RUN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         done_i,
  input  logic         din_i,
  output logic [W-1:0] word_o,
  output logic         zdet_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = {{(W-1){1'b0}}, din_i};
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], din_i};
    end
  end

  // The completed word includes the bit being sampled on the completion edge.
  assign word_o = {sr_q[W-2:0], din_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

`ifdef S2P_ZERO_DETECT_EN
  localparam int ZC_W = $clog2(ZRUN + 1);

  logic [ZC_W-1:0] zc_q, zc_d;

  always_comb begin
    zc_d = zc_q;
    if (done_i) begin
      if (word_o != '0) begin
        zc_d = '0;
      end else if (zc_q < ZC_W'(ZRUN)) begin
        zc_d = zc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zc_q <= '0;
    end else begin
      zc_q <= zc_d;
    end
  end

  assign zdet_o = (zc_q >= ZC_W'(ZRUN));
`else
  logic unused_done;
  assign unused_done = done_i;
  assign zdet_o      = 1'b0;
`endif

endmodule

// File: rtl/s2p_rx.sv
// MSDAP serial-to-parallel receiver: framed MSB-first L/R words into a one-deep
// valid/ack holding register. Optional zero-run detect via S2P_ZERO_DETECT_EN.
module s2p_rx
  import s2p_pkg::*;
(
  input logic  SCLK,
  input logic  CLR,
  s2p_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_prev_q, frame_prev_d;
  logic              rdy_q, rdy_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic [DATA_W-1:0] pdl_q, pdl_d;
  logic [DATA_W-1:0] pdr_q, pdr_d;

  logic              rise;
  logic              load, shift, done;
  logic [DATA_W-1:0] word_l, word_r;
  logic              zdet_l, zdet_r;

  assign rise = bus.EN & bus.FRAME & ~frame_prev_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_prev_d = frame_prev_q;
    ferr_d       = ferr_q;
    load         = 1'b0;
    shift        = 1'b0;
    done         = 1'b0;
    if (bus.EN) begin
      frame_prev_d = bus.FRAME;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            load    = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            // Resync: the current bit becomes the MSB of a fresh word.
            load   = 1'b1;
            cnt_d  = CNT_W'(1);
            ferr_d = 1'b1;
          end else begin
            shift = 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              done    = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rdy_d = rdy_q;
    ovr_d = ovr_q;
    pdl_d = pdl_q;
    pdr_d = pdr_q;
    if (done) begin
      if (!rdy_q || bus.InAck) begin
        pdl_d = word_l;
        pdr_d = word_r;
        rdy_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rdy_q && bus.InAck) begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_prev_q <= 1'b0;
      rdy_q        <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
      pdl_q        <= '0;
      pdr_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_prev_q <= frame_prev_d;
      rdy_q        <= rdy_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
      pdl_q        <= pdl_d;
      pdr_q        <= pdr_d;
    end
  end

  s2p_chan u_chan_l (
    .clk_i   (SCLK),
    .rst_i   (CLR),
    .load_i  (load),
    .shift_i (shift),
    .done_i  (done),
    .din_i   (bus.DATAIN_L),
    .word_o  (word_l),
    .zdet_o  (zdet_l)
  );

  s2p_chan u_chan_r (
    .clk_i   (SCLK),
    .rst_i   (CLR),
    .load_i  (load),
    .shift_i (shift),
    .done_i  (done),
    .din_i   (bus.DATAIN_R),
    .word_o  (word_r),
    .zdet_o  (zdet_r)
  );

  assign bus.PDATA_L   = pdl_q;
  assign bus.PDATA_R   = pdr_q;
  assign bus.InReady   = rdy_q;
  assign bus.FrameErr  = ferr_q;
  assign bus.Overrun   = ovr_q;
  assign bus.ZeroDet_L = zdet_l;
  assign bus.ZeroDet_R = zdet_r;

endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx; build with +define+S2P_ZERO_DETECT_EN to exercise zero detect.
module tb_s2p_rx;
  import s2p_pkg::*;

  logic sclk;
  logic clr;
  int   n_tests;
  int   n_fail;

  s2p_if bus();

  s2p_rx dut (
    .SCLK (sclk),
    .CLR  (clr),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  // Send bits hi..lo of a word pair; FRAME marks bit 15. Each EN cycle is followed
  // by 'gap' EN=0 cycles carrying FRAME=1 and inverted data, which must be ignored.
  task automatic send_range(input logic [15:0] l, input logic [15:0] r,
                            input int hi, input int lo, input int gap, input logic ack_last);
    for (int i = hi; i >= lo; i--) begin
      bus.EN       = 1'b1;
      bus.FRAME    = (i == 15);
      bus.DATAIN_L = l[i];
      bus.DATAIN_R = r[i];
      bus.InAck    = ack_last && (i == 0);
      tick();
      bus.InAck    = 1'b0;
      for (int g = 0; g < gap; g++) begin
        bus.EN       = 1'b0;
        bus.FRAME    = 1'b1;
        bus.DATAIN_L = ~l[i];
        bus.DATAIN_R = ~r[i];
        tick();
      end
    end
    bus.EN    = 1'b0;
    bus.FRAME = 1'b0;
  endtask

  task automatic ack_pulse;
    bus.InAck = 1'b1;
    tick();
    bus.InAck = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    clr          = 1'b1;
    bus.EN       = 1'b0;
    bus.FRAME    = 1'b0;
    bus.DATAIN_L = 1'b0;
    bus.DATAIN_R = 1'b0;
    bus.InAck    = 1'b0;
    tick();
    tick();
    check("rst_pdl", 32'(bus.PDATA_L), 32'h0);
    check("rst_pdr", 32'(bus.PDATA_R), 32'h0);
    check("rst_rdy", 32'(bus.InReady), 32'h0);
    check("rst_ferr", 32'(bus.FrameErr), 32'h0);
    check("rst_ovr", 32'(bus.Overrun), 32'h0);
    check("rst_zl", 32'(bus.ZeroDet_L), 32'h0);
    check("rst_zr", 32'(bus.ZeroDet_R), 32'h0);
    clr = 1'b0;
    tick();

    // Full-rate single frame
    send_range(16'hA5C3, 16'h1234, 15, 1, 0, 1'b0);
    check("t1_rdy_15bits", 32'(bus.InReady), 32'h0);
    send_range(16'hA5C3, 16'h1234, 0, 0, 0, 1'b0);
    check("t1_rdy", 32'(bus.InReady), 32'h1);
    check("t1_pdl", 32'(bus.PDATA_L), 32'hA5C3);
    check("t1_pdr", 32'(bus.PDATA_R), 32'h1234);
    check("t1_ferr", 32'(bus.FrameErr), 32'h0);
    check("t1_ovr", 32'(bus.Overrun), 32'h0);
    ack_pulse();
    check("t1_ack_rdy", 32'(bus.InReady), 32'h0);
    check("t1_hold_pdl", 32'(bus.PDATA_L), 32'hA5C3);

    // EN pulsing 1-in-35
    send_range(16'h8001, 16'h4321, 15, 8, 34, 1'b0);
    check("t2_rdy_mid", 32'(bus.InReady), 32'h0);
    check("t2_hold_pdl", 32'(bus.PDATA_L), 32'hA5C3);
    send_range(16'h8001, 16'h4321, 7, 0, 34, 1'b0);
    check("t2_rdy", 32'(bus.InReady), 32'h1);
    check("t2_pdl", 32'(bus.PDATA_L), 32'h8001);
    check("t2_pdr", 32'(bus.PDATA_R), 32'h4321);
    check("t2_ferr", 32'(bus.FrameErr), 32'h0);
    ack_pulse();
    check("t2_ack_rdy", 32'(bus.InReady), 32'h0);

    // Overrun, then replace with InAck on the completion edge
    send_range(16'h1111, 16'h2222, 15, 0, 0, 1'b0);
    check("t3_rdy", 32'(bus.InReady), 32'h1);
    send_range(16'h3333, 16'h4444, 15, 0, 0, 1'b0);
    check("t3_ovr_pdl", 32'(bus.PDATA_L), 32'h1111);
    check("t3_ovr_pdr", 32'(bus.PDATA_R), 32'h2222);
    check("t3_ovr", 32'(bus.Overrun), 32'h1);
    check("t3_ovr_rdy", 32'(bus.InReady), 32'h1);
    send_range(16'h5555, 16'h6666, 15, 0, 0, 1'b1);
    check("t3_repl_pdl", 32'(bus.PDATA_L), 32'h5555);
    check("t3_repl_pdr", 32'(bus.PDATA_R), 32'h6666);
    check("t3_repl_rdy", 32'(bus.InReady), 32'h1);
    check("t3_repl_ovr", 32'(bus.Overrun), 32'h1);
    ack_pulse();
    check("t3_ack_rdy", 32'(bus.InReady), 32'h0);

    // FRAME re-rises after 7 bits
    send_range(16'hFFFF, 16'hFFFF, 15, 9, 0, 1'b0);
    check("t4_ferr_pre", 32'(bus.FrameErr), 32'h0);
    send_range(16'h00FF, 16'hFF00, 15, 0, 0, 1'b0);
    check("t4_ferr", 32'(bus.FrameErr), 32'h1);
    check("t4_rdy", 32'(bus.InReady), 32'h1);
    check("t4_pdl", 32'(bus.PDATA_L), 32'h00FF);
    check("t4_pdr", 32'(bus.PDATA_R), 32'hFF00);

    // CLR mid-word (after 9 bits)
    send_range(16'h7FFF, 16'h0F0F, 15, 7, 0, 1'b0);
    clr = 1'b1;
    #1;
    check("t5_clr_pdl", 32'(bus.PDATA_L), 32'h0);
    check("t5_clr_pdr", 32'(bus.PDATA_R), 32'h0);
    check("t5_clr_rdy", 32'(bus.InReady), 32'h0);
    check("t5_clr_ferr", 32'(bus.FrameErr), 32'h0);
    check("t5_clr_ovr", 32'(bus.Overrun), 32'h0);
    tick();
    tick();
    clr = 1'b0;
    tick();
    send_range(16'h7FFF, 16'h0F0F, 15, 0, 0, 1'b0);
    check("t5_rdy", 32'(bus.InReady), 32'h1);
    check("t5_pdl", 32'(bus.PDATA_L), 32'h7FFF);
    check("t5_pdr", 32'(bus.PDATA_R), 32'h0F0F);
    check("t5_ferr", 32'(bus.FrameErr), 32'h0);
    check("t5_ovr", 32'(bus.Overrun), 32'h0);
    ack_pulse();

`ifdef S2P_ZERO_DETECT_EN
    for (int k = 0; k < ZERO_RUN; k++) begin
      send_range(16'h0000, 16'h0001, 15, 0, 0, 1'b1);
      if (k == ZERO_RUN - 2) check("t6_zl_799", 32'(bus.ZeroDet_L), 32'h0);
    end
    check("t6_zl_800", 32'(bus.ZeroDet_L), 32'h1);
    check("t6_zr_800", 32'(bus.ZeroDet_R), 32'h0);
    check("t6_ovr", 32'(bus.Overrun), 32'h0);
    send_range(16'h0001, 16'h0001, 15, 0, 0, 1'b1);
    check("t6_zl_clear", 32'(bus.ZeroDet_L), 32'h0);
    check("t6_rdy", 32'(bus.InReady), 32'h1);
    check("t6_pdl", 32'(bus.PDATA_L), 32'h0001);
`else
    send_range(16'h0000, 16'h0000, 15, 0, 0, 1'b1);
    check("t6_pdl_zero", 32'(bus.PDATA_L), 32'h0000);
    check("t6_zl_off", 32'(bus.ZeroDet_L), 32'h0);
    check("t6_zr_off", 32'(bus.ZeroDet_R), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
